// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;

  // Smallest round-index width that can hold 0..rounds.
  function automatic int round_w(input int rounds);
    return $clog2(rounds + 1);
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round index counter: clear beats load beats increment; tc marks the final round.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_W    = round_w(AES128_ROUNDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [ROUND_W-1:0] ld_val,
  input  logic               en,
  output logic [ROUND_W-1:0] idx,
  output logic               tc
);

  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS);

  // Index register; an out-of-range value falls back to zero instead of running past LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (ld) begin
      idx <= ld_val;
    end else if (en) begin
      if (idx >= LAST) idx <= '0;
      else             idx <= idx + 1'b1;
    end
  end

  assign tc = (idx == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: accepts a block, drives load/round/key strobes, holds the result under backpressure.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_W    = round_w(AES128_ROUNDS),
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic               load_state,
  output logic               key_load,
  output logic               round_en,
  output logic               key_step,
  output logic [ROUND_W-1:0] round_idx,
  output logic               last_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count
);

  state_t             state;
  logic               tc;
  logic [ROUND_W-1:0] idx;
  logic               cnt_clr;
  logic               cnt_ld;
  logic               cnt_en;
  logic               done_hs;

  // The index is only meaningful in LOAD/ROUND; everywhere else it sits at zero.
  assign cnt_clr = flush | (state == IDLE) | (state == DONE) | ((state == ROUND) & tc);
  assign cnt_ld  = (state == LOAD);
  assign cnt_en  = (state == ROUND);

  aes_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (cnt_ld),
    .ld_val (ROUND_W'(1)),
    .en     (cnt_en),
    .idx    (idx),
    .tc     (tc)
  );

  // A completed handshake is void if flush arrives in the same cycle.
  assign done_hs = (state == DONE) & out_ready & ~flush;

  // Sequencer state; flush aborts from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= LOAD;
        LOAD:    state <= ROUND;
        ROUND:   if (tc) state <= DONE;
        DONE:    if (out_ready) state <= in_valid ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-block counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_count <= '0;
    else if (done_hs) blk_count <= blk_count + 1'b1;
  end

  // Strobes are pure decodes of registered state, so in_valid never reaches the datapath combinationally.
  assign load_state = (state == LOAD);
  assign key_load   = (state == LOAD);
  assign round_en   = (state == ROUND);
  assign key_step   = (state == ROUND);
  assign last_round = (state == ROUND) & tc;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign round_idx  = idx;
  assign in_ready   = ~rst & ~flush & ((state == IDLE) | ((state == DONE) & out_ready));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default AES-128 instance plus a 14-round, 2-bit-counter instance.
module tb_aes_round_ctrl;
  import aes_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  // default instance
  logic        in_valid, in_ready, flush, out_ready;
  logic        load_state, key_load, round_en, key_step, last_round, out_valid, busy;
  logic [3:0]  round_idx;
  logic [15:0] blk_count;
  // 14-round, CNT_W=2 instance
  logic        b_in_valid, b_in_ready, b_flush, b_out_ready;
  logic        b_load_state, b_key_load, b_round_en, b_key_step, b_last_round, b_out_valid, b_busy;
  logic [3:0]  b_round_idx;
  logic [1:0]  b_blk_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .load_state(load_state), .key_load(key_load), .round_en(round_en), .key_step(key_step),
    .round_idx(round_idx), .last_round(last_round), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .blk_count(blk_count)
  );

  aes_round_ctrl #(.NUM_ROUNDS(AES256_ROUNDS), .ROUND_W(4), .CNT_W(2)) dut14 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .load_state(b_load_state), .key_load(b_key_load), .round_en(b_round_en), .key_step(b_key_step),
    .round_idx(b_round_idx), .last_round(b_last_round), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy), .blk_count(b_blk_count)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic        ls;   // load_state and key_load
    logic        re;   // round_en and key_step
    logic        lr;
    logic        ov;
    logic        bsy;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [27:0] snap1();
    return {load_state, key_load, round_en, key_step, round_idx, last_round,
            out_valid, busy, in_ready, blk_count};
  endfunction

  function automatic logic [27:0] exp_of(input vec_t v);
    return {v.ls, v.ls, v.re, v.re, v.idx, v.lr, v.ov, v.bsy, v.rdy, v.cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Presents one block on the default instance (called at a negedge); returns at the
  // negedge where out_valid is first seen, with lat = edges since presentation.
  task automatic run_block1(input logic ordy, output int lat, output int nre);
    lat = 0; nre = 0;
    in_valid = 1'b1; out_ready = ordy;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (round_en) nre++;
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic run_block2(output int lat, output int nre, output int nks, output int nlr, output int nld);
    lat = 0; nre = 0; nks = 0; nlr = 0; nld = 0;
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      if (b_round_en) nre++;
      if (b_key_step) nks++;
      if (b_last_round && b_round_idx == 4'd14) nlr++;
      if (b_last_round && b_round_idx != 4'd14) nlr += 100;
      if (b_load_state && b_key_load) nld++;
      if (b_out_valid) begin lat = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nre, nks, nlr, nld, hits;
    logic [1:0] wrap_seq [5];
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

    // Single-block trace: index = posedges since in_valid was presented.
    tbl[0]  = '{idx:4'd0, ls:1'b0, re:1'b0, lr:1'b0, ov:1'b0, bsy:1'b0, rdy:1'b1, cnt:16'd0};
    tbl[1]  = '{idx:4'd0, ls:1'b1, re:1'b0, lr:1'b0, ov:1'b0, bsy:1'b1, rdy:1'b0, cnt:16'd0};
    for (int k = 2; k <= 11; k++)
      tbl[k] = '{idx:4'(k-1), ls:1'b0, re:1'b1, lr:(k == 11), ov:1'b0, bsy:1'b1, rdy:1'b0, cnt:16'd0};
    tbl[12] = '{idx:4'd0, ls:1'b0, re:1'b0, lr:1'b0, ov:1'b1, bsy:1'b1, rdy:1'b1, cnt:16'd0};
    tbl[13] = '{idx:4'd0, ls:1'b0, re:1'b0, lr:1'b0, ov:1'b0, bsy:1'b0, rdy:1'b1, cnt:16'd1};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    #1;
    check("reset outputs", 32'(snap1()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Table-driven single block
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = (k == 0);
      out_ready = 1'b1;
      #1;
      check($sformatf("block1 step %0d", k), 32'(snap1()), 32'(exp_of(tbl[k])));
    end

    // Backpressure: DONE held for 5 cycles with in_valid high
    run_block1(1'b0, lat, nre);
    check("bp latency", lat, 12);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check($sformatf("bp hold %0d", k), 32'(snap1()),
            32'(exp_of('{idx:4'd0, ls:1'b0, re:1'b0, lr:1'b0, ov:1'b1, bsy:1'b1, rdy:1'b0, cnt:16'd1})));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp count", 32'(blk_count), 32'd2);
    check("bp idle", 32'(busy), 32'd0);

    // Back-to-back: three blocks in 36 cycles
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      check($sformatf("b2b ls/ov edge %0d", k), {30'd0, load_state, out_valid},
            {30'd0, (k % 12) == 1, (k % 12) == 0});
      if (k == 36) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b count", 32'(blk_count), 32'd5);
    check("b2b idle", 32'(busy), 32'd0);

    // Flush at round_idx 5
    in_valid = 1'b1;
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (round_en && round_idx == 4'd5) begin hits = 1; break; end
    end
    check("reached round 5", hits, 1);
    flush = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("after flush", 32'(snap1()),
          32'(exp_of('{idx:4'd0, ls:1'b0, re:1'b0, lr:1'b0, ov:1'b0, bsy:1'b0, rdy:1'b1, cnt:16'd5})));
    run_block1(1'b1, lat, nre);
    check("post-flush latency", lat, 12);
    check("post-flush rounds", nre, 10);
    @(negedge clk);
    check("post-flush count", 32'(blk_count), 32'd6);

    // Flush coinciding with the output handshake
    run_block1(1'b0, lat, nre);
    check("flush-hs latency", lat, 12);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush-hs dropped", {15'd0, busy, blk_count}, {15'd0, 1'b0, 16'd6});

    // Async reset between edges in ROUND
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-rst in round", 32'(round_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst outputs", 32'(snap1()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst ready/count", {15'd0, in_ready, blk_count}, {15'd0, 1'b1, 16'd0});
    hits = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid || busy) hits++;
    end
    check("no output after rst", hits, 0);

    // 14 rounds, 2-bit wrapping counter
    for (int b = 0; b < 5; b++) begin
      #1;
      check($sformatf("r14 ready blk %0d", b), {31'd0, b_in_ready}, 32'd1);
      @(negedge clk);
      run_block2(lat, nre, nks, nlr, nld);
      check($sformatf("r14 latency blk %0d", b), lat, 16);
      check($sformatf("r14 rounds blk %0d", b), nre, 14);
      check($sformatf("r14 strobes blk %0d", b), {nks[7:0], nlr[7:0], nld[7:0]}, {8'd14, 8'd1, 8'd1});
      @(negedge clk);
      check($sformatf("r14 count blk %0d", b), {29'd0, b_busy, b_blk_count}, {29'd0, 1'b0, wrap_seq[b]});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
